axil_read_handler: RTL and testbench
====================================

// Module: axil_read_handler
// PURPOSE
//  AXI4-Lite read-channel initiator, the companion to axi_write_handler.
//  Turns a one-cycle user read request into an AR handshake plus an R handshake
//  on an AXI4-Lite slave (e.g. axil_ram), and returns the data as a one-cycle pulse.
//  Also keeps a saturating count of error responses and the latency of the last
//  read, so HLS-generated datapaths and testbenches can poll them.
// PARAMETERS
//  DATA_WIDTH     32  width of the rdata and read_data buses
//  ADDR_WIDTH     5   width of the araddr and read_addr buses
//  ERR_CNT_WIDTH  8   width of err_count (saturating)
//  LAT_WIDTH      16  width of last_latency (saturating)
// PORTS
//  clk             in   1              single clock; all logic on posedge
//  rst             in   1              synchronous, active-high reset
//  read_addr       in   ADDR_WIDTH     user read address; sampled when a request is accepted
//  start_read      in   1              read request; accepted only when ready=1
//  ready           out  1              1 = idle, can accept a request
//  read_data       out  DATA_WIDTH     last returned data; held until the next completion
//  read_valid      out  1              one-cycle pulse: read_data/read_error are new
//  read_error      out  1              with read_valid: rresp != OKAY
//  err_count       out  ERR_CNT_WIDTH  number of error responses since reset (saturates)
//  last_latency    out  LAT_WIDTH      cycles from request acceptance to R handshake
//  s_axil_araddr   out  ADDR_WIDTH     AR address
//  s_axil_arprot   out  3              tied to 3'b000
//  s_axil_arvalid  out  1              AR valid
//  s_axil_arready  in   1              AR ready from slave
//  s_axil_rdata    in   DATA_WIDTH     R data from slave
//  s_axil_rresp    in   2              R response from slave
//  s_axil_rvalid   in   1              R valid from slave
//  s_axil_rready   out  1              R ready
// BEHAVIOUR
//  Reset (rst=1 at posedge; dominates every other input):
//   ready=1; arvalid=0; rready=0; read_valid=0; read_error=0.
//   read_data=0; araddr=0; err_count=0; last_latency=0; state=IDLE.
//   An in-flight transaction is abandoned with no read_valid; the slave is reset in the same domain.
//  All outputs are registered. States: IDLE, AR, R.
//  IDLE: ready=1.
//   start_read=1 -> araddr<=read_addr, arvalid<=1, ready<=0, lat counter<=0 -> AR.
//  AR: arvalid and araddr held stable until arready=1 at a posedge.
//   Counter +1 each edge.
//   At the handshake edge: arvalid<=0, rready<=1 -> R.
//   rready is 0 throughout AR, so no R handshake can happen before the AR handshake.
//  R: counter +1 each edge. On rvalid&&rready:
//   read_data<=rdata; read_error<=(rresp!=OKAY); read_valid<=1 for one cycle.
//   rready<=0; ready<=1; last_latency<=counter+1.
//   err_count +1 if error (saturating) -> IDLE.
//  Minimum latency:
//   Request accepted at edge N, AR handshake at N+1, R handshake at N+2.
//   read_valid and ready go high after N+2, so last_latency=2.
//   The next request can be accepted at N+3.
//  start_read while ready=0 is ignored: no queueing, and araddr is unchanged.
//  read_valid deasserts on the following edge unconditionally.
//  read_error is cleared on the next completion only.
//  Counters saturate at all-ones and never wrap. There is no timeout: the FSM waits indefinitely.
//  EXOKAY (2'b01) counts as an error, because AXI4-Lite has no exclusive access.
// STRUCTURE
//  Shared package axil_pkg holds:
//   AXIL_RESP_OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
//   AXIL_PROT_DEFAULT=3'b000.
//   The read-FSM state encoding {IDLE, AR, R}.
//  One natural sub-module: sat_counter (WIDTH, clr, inc, value).
//   Used twice: once for err_count, once for the latency counter.
//  FSM and datapath live in the top module.
// TESTING
//  T1 Reset: rst high for 2 edges -> ready=1, arvalid=0, rready=0, read_valid=0, err_count=0, last_latency=0.
//  T2 axil_ram (32/5): write 2345 to addr 1 via axi_write_handler, then start_read with addr 1.
//     -> araddr=1 while arvalid; exactly one read_valid pulse.
//     -> read_data=2345, read_error=0, last_latency=2.
//  T3 Stub slave withholds arready for 5 edges, then asserts rvalid 3 edges after rready.
//     -> arvalid/araddr stable throughout; rready=0 until the AR handshake; last_latency=9.
//  T4 Stub returns rresp=2'b10, rdata=32'hDEADBEEF.
//     -> read_valid pulse, read_error=1, read_data=32'hDEADBEEF, err_count 0->1, ready back to 1.
//  T5 start_read with addr 7 pulsed while in AR, during a read of addr 3.
//     -> araddr stays 3; a single completion; no second AR.
//  T6 rst asserted while in R with rvalid=0.
//     -> after that edge: ready=1, rready=0, no read_valid; the next read of addr 1 completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response/prot constants and the read-FSM state encoding
package axil_pkg;
   localparam logic [1:0] AXIL_RESP_OKAY    = 2'b00;
   localparam logic [1:0] AXIL_RESP_EXOKAY  = 2'b01;
   localparam logic [1:0] AXIL_RESP_SLVERR  = 2'b10;
   localparam logic [1:0] AXIL_RESP_DECERR  = 2'b11;
   localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;
   typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} rd_state_t;
endpackage

// File: rtl/axil_read_handler_sat_counter.sv
// sat_counter: counter that clears on clr, increments on inc and sticks at all-ones
//   clk, rst : clock, synchronous active-high reset
//   clr      : clear to zero (wins over inc)
//   inc      : increment by one unless already saturated
//   value    : current count
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);
   always_ff @(posedge clk) begin
      if (rst || clr) value <= '0;
      else if (inc && !(&value)) value <= value + 1'b1;
   end
endmodule

// File: rtl/axil_read_handler.sv
// axil_read_handler: AXI4-Lite read initiator turning a one-cycle request into AR+R handshakes
//   user side : read_addr/start_read in, ready/read_data/read_valid/read_error out,
//               err_count (saturating error responses), last_latency (accept-to-R cycles)
//   AXI side  : s_axil_ar* (address channel out), s_axil_r* (data channel in, rready out)
module axil_read_handler import axil_pkg::*; #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int ERR_CNT_WIDTH = 8,
   parameter int LAT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDR_WIDTH-1:0]    read_addr,
   input  logic                     start_read,
   output logic                     ready,
   output logic [DATA_WIDTH-1:0]    read_data,
   output logic                     read_valid,
   output logic                     read_error,
   output logic [ERR_CNT_WIDTH-1:0] err_count,
   output logic [LAT_WIDTH-1:0]     last_latency,
   output logic [ADDR_WIDTH-1:0]    s_axil_araddr,
   output logic [2:0]               s_axil_arprot,
   output logic                     s_axil_arvalid,
   input  logic                     s_axil_arready,
   input  logic [DATA_WIDTH-1:0]    s_axil_rdata,
   input  logic [1:0]               s_axil_rresp,
   input  logic                     s_axil_rvalid,
   output logic                     s_axil_rready
);
   rd_state_t            r_state, w_state_next;
   logic                 w_accept, w_ar_hs, w_r_hs, w_r_err;
   logic [LAT_WIDTH-1:0] w_lat_cnt;
   assign s_axil_arprot = AXIL_PROT_DEFAULT;
   // rready is high exactly in ST_R and arvalid exactly in ST_AR, so the
   // handshakes reduce to state plus the slave's signal.
   always_comb begin
      w_accept     = (r_state == ST_IDLE) && start_read;
      w_ar_hs      = (r_state == ST_AR) && s_axil_arready;
      w_r_hs       = (r_state == ST_R) && s_axil_rvalid;
      w_r_err      = s_axil_rresp != AXIL_RESP_OKAY;
      w_state_next = r_state;
      if (w_accept) w_state_next = ST_AR;
      else if (w_ar_hs) w_state_next = ST_R;
      else if (w_r_hs) w_state_next = ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else r_state <= w_state_next;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ready          <= 1'b1;
         s_axil_arvalid <= 1'b0;
         s_axil_araddr  <= '0;
         s_axil_rready  <= 1'b0;
         read_valid     <= 1'b0;
         read_error     <= 1'b0;
         read_data      <= '0;
         last_latency   <= '0;
      end else begin
         read_valid <= w_r_hs;
         if (w_accept) begin
            s_axil_araddr  <= read_addr;
            s_axil_arvalid <= 1'b1;
            ready          <= 1'b0;
         end
         if (w_ar_hs) begin
            s_axil_arvalid <= 1'b0;
            s_axil_rready  <= 1'b1;
         end
         if (w_r_hs) begin
            s_axil_rready <= 1'b0;
            ready         <= 1'b1;
            read_data     <= s_axil_rdata;
            read_error    <= w_r_err;
            // count excludes the completing edge itself, hence the +1
            last_latency  <= &w_lat_cnt ? w_lat_cnt : w_lat_cnt + 1'b1;
         end
      end
   end
   sat_counter #(.WIDTH(LAT_WIDTH)) u_lat_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_accept),
      .inc   (r_state != ST_IDLE),
      .value (w_lat_cnt)
   );
   sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (w_r_hs && w_r_err),
      .value (err_count)
   );
endmodule

// File: tb/tb_axil_read_handler.sv
module tb_axil_read_handler;
   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  read_addr;
   logic        start_read;
   logic        ready;
   logic [31:0] read_data;
   logic        read_valid;
   logic        read_error;
   logic [7:0]  err_count;
   logic [15:0] last_latency;
   logic [4:0]  s_axil_araddr;
   logic [2:0]  s_axil_arprot;
   logic        s_axil_arvalid;
   logic        s_axil_arready;
   logic [31:0] s_axil_rdata;
   logic [1:0]  s_axil_rresp;
   logic        s_axil_rvalid;
   logic        s_axil_rready;

   typedef struct packed {
      logic [31:0] d;
      logic        e;
      logic [15:0] l;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          n_done = 0;
   int          n_ar = 0;
   logic [31:0] mem [32];
   logic [1:0]  sl_resp;
   int          ar_delay;
   int          r_delay;
   logic [4:0]  sl_exp_addr;
   logic        prev_rv = 1'b0;

   always #5 clk = ~clk;

   axil_read_handler dut (
      .clk            (clk),
      .rst            (rst),
      .read_addr      (read_addr),
      .start_read     (start_read),
      .ready          (ready),
      .read_data      (read_data),
      .read_valid     (read_valid),
      .read_error     (read_error),
      .err_count      (err_count),
      .last_latency   (last_latency),
      .s_axil_araddr  (s_axil_araddr),
      .s_axil_arprot  (s_axil_arprot),
      .s_axil_arvalid (s_axil_arvalid),
      .s_axil_arready (s_axil_arready),
      .s_axil_rdata   (s_axil_rdata),
      .s_axil_rresp   (s_axil_rresp),
      .s_axil_rvalid  (s_axil_rvalid),
      .s_axil_rready  (s_axil_rready)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   // Stub slave: withholds arready for ar_delay sightings of arvalid, then
   // keeps rvalid low for r_delay cycles of rready before answering.
   initial begin
      int st;
      int cnt;
      st = 0;
      cnt = 0;
      s_axil_arready = 1'b0;
      s_axil_rvalid  = 1'b0;
      s_axil_rdata   = '0;
      s_axil_rresp   = 2'b00;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            st = 0;
            cnt = 0;
            s_axil_arready = 1'b0;
            s_axil_rvalid  = 1'b0;
         end else begin
            if (st == 0 && s_axil_arready) begin
               n_ar++;
               chk("arvalid_drop", s_axil_arvalid, 1'b0);
               s_axil_arready = 1'b0;
               st = 1;
               cnt = 0;
            end
            if (st == 0) begin
               if (s_axil_arvalid) begin
                  chk("araddr_stable", s_axil_araddr, sl_exp_addr);
                  chk("rready_low_in_ar", s_axil_rready, 1'b0);
                  if (cnt == ar_delay) s_axil_arready = 1'b1;
                  else cnt++;
               end
            end else if (s_axil_rvalid) begin
               s_axil_rvalid = 1'b0;
               st = 0;
               cnt = 0;
            end else if (s_axil_rready) begin
               if (cnt == r_delay) begin
                  s_axil_rvalid = 1'b1;
                  s_axil_rdata  = mem[sl_exp_addr];
                  s_axil_rresp  = sl_resp;
               end else cnt++;
            end
         end
      end
   end

   // Monitor: every completion pops one expected response.
   always @(negedge clk) begin
      if (!rst && read_valid) begin
         exp_t e;
         n_done++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_read_valid: got data %0h, none expected", read_data);
         end else begin
            e = exp_q.pop_front();
            chk("read_data", read_data, e.d);
            chk("read_error", read_error, e.e);
            chk("last_latency", last_latency, e.l);
            chk("ready_at_done", ready, 1'b1);
         end
         chk("read_valid_one_cycle", prev_rv, 1'b0);
      end
      prev_rv = read_valid;
   end

   task automatic do_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] rs,
                          input int ard, input int rd, input bit push);
      int n;
      mem[a] = d;
      sl_resp = rs;
      ar_delay = ard;
      r_delay = rd;
      sl_exp_addr = a;
      if (push) exp_q.push_back({d, rs != 2'b00, 16'(2 + ard + rd)});
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL wait_ready: got ready=0 after %0d cycles, want 1", n);
      end
      read_addr = a;
      start_read = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
   endtask

   task automatic wait_done(input int c0);
      int n;
      n = 0;
      while (n_done == c0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n_done == c0) begin
         total++;
         bad++;
         $display("FAIL wait_done: got no completion after %0d cycles, want one", n);
      end
      @(negedge clk);
   endtask

   initial begin
      int c;
      int a0;
      rst = 1'b1;
      start_read = 1'b0;
      read_addr = '0;
      sl_resp = 2'b00;
      ar_delay = 0;
      r_delay = 0;
      sl_exp_addr = '0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      // T1 reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t1_ready", ready, 1'b1);
      chk("t1_arvalid", s_axil_arvalid, 1'b0);
      chk("t1_rready", s_axil_rready, 1'b0);
      chk("t1_read_valid", read_valid, 1'b0);
      chk("t1_err_count", err_count, 8'd0);
      chk("t1_last_latency", last_latency, 16'd0);
      chk("t1_read_data", read_data, 32'd0);
      chk("t1_arprot", s_axil_arprot, 3'b000);
      rst = 1'b0;
      // T2 minimum-latency read of 2345 from addr 1
      c = n_done;
      do_read(5'd1, 32'd2345, 2'b00, 0, 0, 1'b1);
      wait_done(c);
      repeat (5) @(negedge clk);
      chk("t2_one_pulse", n_done - c, 1);
      chk("t2_latency", last_latency, 16'd2);
      chk("t2_data", read_data, 32'd2345);
      // T3 slow slave: 5 edges without arready, 2 idle rready cycles -> latency 9
      c = n_done;
      do_read(5'd5, 32'h1234_5678, 2'b00, 5, 2, 1'b1);
      wait_done(c);
      chk("t3_latency", last_latency, 16'd9);
      // T4 SLVERR
      chk("t4_err_before", err_count, 8'd0);
      c = n_done;
      do_read(5'd3, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b1);
      wait_done(c);
      chk("t4_err_after", err_count, 8'd1);
      chk("t4_read_error", read_error, 1'b1);
      chk("t4_data", read_data, 32'hDEAD_BEEF);
      chk("t4_ready", ready, 1'b1);
      // T5 request for addr 7 while the addr 3 read sits in AR
      c = n_done;
      a0 = n_ar;
      do_read(5'd3, 32'h0000_0033, 2'b00, 3, 0, 1'b1);
      read_addr = 5'd7;
      start_read = 1'b1;
      @(negedge clk);
      start_read = 1'b0;
      wait_done(c);
      repeat (6) @(negedge clk);
      chk("t5_one_ar", n_ar - a0, 1);
      chk("t5_one_done", n_done - c, 1);
      chk("t5_araddr", s_axil_araddr, 5'd3);
      chk("t5_read_error_cleared", read_error, 1'b0);
      // T6 reset while waiting in R
      c = n_done;
      do_read(5'd1, 32'd2345, 2'b00, 0, 20, 1'b0);
      @(negedge clk);
      chk("t6_in_r", s_axil_rready, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_ready", ready, 1'b1);
      chk("t6_rready", s_axil_rready, 1'b0);
      chk("t6_read_valid", read_valid, 1'b0);
      chk("t6_arvalid", s_axil_arvalid, 1'b0);
      chk("t6_err_count", err_count, 8'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_done", n_done - c, 0);
      do_read(5'd1, 32'd2345, 2'b00, 0, 0, 1'b1);
      wait_done(c);
      chk("t6_latency", last_latency, 16'd2);
      chk("t6_data", read_data, 32'd2345);
      repeat (4) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit");
      $fatal(1, "watchdog");
   end
endmodule
